dec_issue_ctrl: RTL and testbench
=================================

// Module: dec_issue_ctrl
// PURPOSE
//  Sequences the decode stage: buffers fetched instructions in a small queue and presents the head to the decoder.
//  Tracks register busy state in a scoreboard and stalls on RAW/WAW hazards.
//  Hands issued instructions to execute over a valid/ready handshake and raises illegal-instruction exceptions.
//  Sits between the fetch unit and execute, alongside the decoder.
// PARAMETERS
//  XLEN         32  datapath width (riscv package)
//  QUEUE_DEPTH  2   instruction queue entries; power of 2, >=2
//  NB_REGS      32  architectural integer registers (scoreboard width)
// PORTS
//  clk              in   1     clock
//  reset_n          in   1     async active-low reset
//  if_valid_i       in   1     fetch offers instruction
//  if_ready_o       out  1     queue accepts instruction
//  if_instr_i       in   XLEN  fetched instruction word
//  if_pc_i          in   XLEN  fetched PC
//  dec_instr_o      out  XLEN  queue head to decoder (0x00000013 when empty)
//  dec_pc_o         out  XLEN  queue head PC to decoder (0 when empty)
//  dec_illegal_i    in   1     decoder: head is illegal
//  dec_rd_v_i/dec_rd_i    in 1/5  decoder destination
//  dec_rs1_v_i/dec_rs1_i  in 1/5  decoder source 1
//  dec_rs2_v_i/dec_rs2_i  in 1/5  decoder source 2
//  issue_valid_o    out  1     head issuable this cycle
//  issue_ready_i    in   1     execute accepts
//  issue_pc_o       out  XLEN  PC of issued instruction (= dec_pc_o)
//  wb_valid_i       in   1     writeback retires a destination
//  wb_rd_i          in   5     register cleared in scoreboard
//  exc_valid_o      out  1     illegal-instruction exception request
//  exc_ready_i      in   1     trap unit accepts exception
//  exc_pc_o         out  XLEN  faulting PC
//  exc_tval_o       out  XLEN  faulting instruction word
//  flush_i          in   1     pipeline flush (branch/trap redirect)
// BEHAVIOUR
//  Reset (async, reset_n=0): queue empty; busy=0; state=RUN.
//   All valid/ready outputs 0; data outputs 0, except dec_instr_o=NOP.
//  Queue: push when if_valid_i & if_ready_o.
//   if_ready_o = !full & state==RUN & !flush_i; no push-through when full.
//   Pop on issue fire (issue_valid_o & issue_ready_i).
//  Decode is combinational: head -> decoder -> controller, zero-cycle latency; issue fires the same cycle as head is valid.
//  hazard = any of:
//   (rs1_v & rs1!=0 & busy[rs1]) | (rs2_v & rs2!=0 & busy[rs2]) | (rd_v & rd!=0 & busy[rd]).
//  busy is registered. A wb clear in cycle N unblocks the head in cycle N+1.
//  issue_valid_o = !empty & state==RUN & !hazard & !dec_illegal_i & !flush_i.
//  On issue fire with rd_v & rd!=0: busy[rd] <= 1.
//  On wb_valid_i & wb_rd_i!=0: busy[wb_rd_i] <= 0.
//   Same register set and cleared in the same cycle: set wins.
//  busy[0] is hardwired 0.
//  FSM RUN:
//   Head illegal & !flush_i -> exc_valid_o=1, exc_pc_o/exc_tval_o = head; hold stable until exc_ready_i.
//   On accept -> TRAP_WAIT; head is not popped.
//  FSM TRAP_WAIT: if_ready_o=0, issue_valid_o=0, exc_valid_o=0; wait for flush_i.
//  flush_i (any state, highest priority): queue emptied next cycle; state -> RUN.
//   Same-cycle push/pop/exception accept are ignored. busy is untouched (in-flight ops still write back).
//  Reset mid-operation discards everything and returns to the reset state.
// CONFIGURATION
//  DEC_PERF_CNT_EN defined:
//   Adds outputs perf_issue_cnt_o and perf_hazard_cnt_o (XLEN each, reset 0, wrap at 2^XLEN).
//   Count issue fires, and cycles with a non-empty head, RUN state and hazard=1.
//  DEC_PERF_CNT_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  riscv package: dec_ctrl_state_e {RUN, TRAP_WAIT}; NOP_INSTR=32'h00000013; ifq_entry_t {instr, pc}.
//  Sub-module dec_ifq: QUEUE_DEPTH FIFO of ifq_entry_t with push/pop/flush and full/empty.
//  Scoreboard, hazard logic and FSM live in this module.
// TESTING
//  1. Reset, push addi x1 @0x100, issue_ready_i=1 -> issue_valid_o same cycle, issue_pc_o=0x100, busy[1]=1.
//  2. add x2,x1,x1 follows; no wb -> stall.
//     wb_rd_i=1 in cycle N -> issue in N+1; perf_hazard_cnt_o counts stall cycles when enabled.
//  3. Push 3 instructions, issue_ready_i=0 -> if_ready_o=0 after 2; release -> FIFO order preserved.
//  4. Illegal 0x00000000 @0x200 -> exc_valid_o, exc_pc_o=0x200, exc_tval_o=0.
//     Held until exc_ready_i, then TRAP_WAIT; flush_i -> RUN, queue empty.
//  5. flush_i with 2 entries queued and if_valid_i=1 -> no push; queue empty next cycle; busy unchanged.
//  6. addi x0 issued -> busy stays 0; wb_rd_i=5 with simultaneous issue writing x5 -> busy[5]=1.

Source files
------------

// File: rtl/dec_issue_ctrl_pkg.sv
// Shared types and constants for the decode/issue controller.
package dec_issue_ctrl_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {RUN, TRAP_WAIT} dec_ctrl_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } ifq_entry_t;
endpackage

// File: rtl/dec_issue_ctrl_ifq.sv
// dec_ifq: small instruction FIFO with flush; pointers carry an extra wrap bit.
module dec_ifq
  import dec_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  ifq_entry_t push_data,
  output ifq_entry_t head,
  output logic       empty,
  output logic       full
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  ifq_entry_t  mem_q [DEPTH];
  ifq_entry_t  mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
  assign head  = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push && !full) begin
        mem_d[wr_ptr_q[PW-1:0]] = push_data;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only visible while !empty.
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/dec_issue_ctrl.sv
// Decode-stage sequencer: fetch queue, register scoreboard, hazard stall, illegal trap FSM.
// Optional performance counters are enabled with DEC_PERF_CNT_EN.
module dec_issue_ctrl
  import dec_issue_ctrl_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2,
  parameter int NB_REGS     = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [XLEN-1:0] if_instr_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic [XLEN-1:0] dec_instr_o,
  output logic [XLEN-1:0] dec_pc_o,
  input  logic            dec_illegal_i,
  input  logic            dec_rd_v_i,
  input  logic [4:0]      dec_rd_i,
  input  logic            dec_rs1_v_i,
  input  logic [4:0]      dec_rs1_i,
  input  logic            dec_rs2_v_i,
  input  logic [4:0]      dec_rs2_i,
  output logic            issue_valid_o,
  input  logic            issue_ready_i,
  output logic [XLEN-1:0] issue_pc_o,
  input  logic            wb_valid_i,
  input  logic [4:0]      wb_rd_i,
  output logic            exc_valid_o,
  input  logic            exc_ready_i,
  output logic [XLEN-1:0] exc_pc_o,
  output logic [XLEN-1:0] exc_tval_o,
`ifdef DEC_PERF_CNT_EN
  output logic [XLEN-1:0] perf_issue_cnt_o,
  output logic [XLEN-1:0] perf_hazard_cnt_o,
`endif
  input  logic            flush_i
);
  dec_ctrl_state_e    state_q, state_d;
  logic [NB_REGS-1:0] busy_q, busy_d;
  ifq_entry_t         head, push_data;
  logic               empty, full, push, fire, hazard, run;

  assign push_data = '{instr: if_instr_i, pc: if_pc_i};

  dec_ifq #(.DEPTH(QUEUE_DEPTH)) u_ifq (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (fire),
    .flush    (flush_i),
    .push_data(push_data),
    .head     (head),
    .empty    (empty),
    .full     (full)
  );

  assign run         = (state_q == RUN);
  assign dec_instr_o = empty ? NOP_INSTR : head.instr;
  assign dec_pc_o    = empty ? '0 : head.pc;
  assign issue_pc_o  = dec_pc_o;

  assign hazard = (dec_rs1_v_i && (dec_rs1_i != '0) && busy_q[dec_rs1_i])
               || (dec_rs2_v_i && (dec_rs2_i != '0) && busy_q[dec_rs2_i])
               || (dec_rd_v_i  && (dec_rd_i  != '0) && busy_q[dec_rd_i]);

  // reset_n gate keeps the ready low while the block is held in reset.
  assign if_ready_o    = reset_n && !full && run && !flush_i;
  assign push          = if_valid_i && if_ready_o;
  assign issue_valid_o = !empty && run && !hazard && !dec_illegal_i && !flush_i;
  assign fire          = issue_valid_o && issue_ready_i;
  assign exc_valid_o   = !empty && run && dec_illegal_i && !flush_i;
  assign exc_pc_o      = exc_valid_o ? head.pc    : '0;
  assign exc_tval_o    = exc_valid_o ? head.instr : '0;

  always_comb begin
    state_d = state_q;
    if (flush_i)                         state_d = RUN;
    else if (exc_valid_o && exc_ready_i) state_d = TRAP_WAIT;
  end

  // Clear before set so an issue claiming the retiring register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_i && (wb_rd_i != '0))          busy_d[wb_rd_i]  = 1'b0;
    if (fire && dec_rd_v_i && (dec_rd_i != '0)) busy_d[dec_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

`ifdef DEC_PERF_CNT_EN
  logic [XLEN-1:0] perf_issue_cnt_q, perf_issue_cnt_d;
  logic [XLEN-1:0] perf_hazard_cnt_q, perf_hazard_cnt_d;

  always_comb begin
    perf_issue_cnt_d  = perf_issue_cnt_q  + {{(XLEN-1){1'b0}}, fire};
    perf_hazard_cnt_d = perf_hazard_cnt_q + {{(XLEN-1){1'b0}}, (!empty && run && hazard)};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_issue_cnt_q  <= '0;
      perf_hazard_cnt_q <= '0;
    end else begin
      perf_issue_cnt_q  <= perf_issue_cnt_d;
      perf_hazard_cnt_q <= perf_hazard_cnt_d;
    end
  end

  assign perf_issue_cnt_o  = perf_issue_cnt_q;
  assign perf_hazard_cnt_o = perf_hazard_cnt_q;
`endif
endmodule

// File: tb/tb_dec_issue_ctrl.sv
// Directed bench for dec_issue_ctrl; the bench plays the role of fetch, decoder, execute and writeback.
module tb_dec_issue_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_valid_i, if_ready_o;
  logic [31:0] if_instr_i, if_pc_i, dec_instr_o, dec_pc_o;
  logic        dec_illegal_i, dec_rd_v_i, dec_rs1_v_i, dec_rs2_v_i;
  logic [4:0]  dec_rd_i, dec_rs1_i, dec_rs2_i, wb_rd_i;
  logic        issue_valid_o, issue_ready_i, wb_valid_i;
  logic [31:0] issue_pc_o, exc_pc_o, exc_tval_o;
  logic        exc_valid_o, exc_ready_i, flush_i;
`ifdef DEC_PERF_CNT_EN
  logic [31:0] perf_issue_cnt_o, perf_hazard_cnt_o;
`endif

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  dec_issue_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
    .if_instr_i(if_instr_i), .if_pc_i(if_pc_i),
    .dec_instr_o(dec_instr_o), .dec_pc_o(dec_pc_o),
    .dec_illegal_i(dec_illegal_i),
    .dec_rd_v_i(dec_rd_v_i), .dec_rd_i(dec_rd_i),
    .dec_rs1_v_i(dec_rs1_v_i), .dec_rs1_i(dec_rs1_i),
    .dec_rs2_v_i(dec_rs2_v_i), .dec_rs2_i(dec_rs2_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_pc_o(issue_pc_o),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
    .exc_valid_o(exc_valid_o), .exc_ready_i(exc_ready_i),
    .exc_pc_o(exc_pc_o), .exc_tval_o(exc_tval_o),
`ifdef DEC_PERF_CNT_EN
    .perf_issue_cnt_o(perf_issue_cnt_o), .perf_hazard_cnt_o(perf_hazard_cnt_o),
`endif
    .flush_i(flush_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow a further settle delay.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic dec(input logic rdv, input logic [4:0] rd, input logic r1v, input logic [4:0] r1,
                     input logic r2v, input logic [4:0] r2);
    dec_rd_v_i = rdv; dec_rd_i = rd; dec_rs1_v_i = r1v; dec_rs1_i = r1;
    dec_rs2_v_i = r2v; dec_rs2_i = r2;
  endtask

  task automatic fetch(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    if_valid_i = v; if_instr_i = instr; if_pc_i = pc;
  endtask

  initial begin
    reset_n = 1'b0; flush_i = 1'b0; dec_illegal_i = 1'b0;
    issue_ready_i = 1'b0; exc_ready_i = 1'b0; wb_valid_i = 1'b0; wb_rd_i = '0;
    fetch(1'b0, '0, '0); dec(0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_if_ready", {31'd0, if_ready_o}, 0);
    chk("rst_issue_valid", {31'd0, issue_valid_o}, 0);
    chk("rst_exc_valid", {31'd0, exc_valid_o}, 0);
    chk("rst_dec_instr", dec_instr_o, 32'h13);
    chk("rst_dec_pc", dec_pc_o, 0);
    chk("rst_exc_pc", exc_pc_o, 0);
    chk("rst_exc_tval", exc_tval_o, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // 1: addi x1 issues the cycle it reaches the head
    issue_ready_i = 1'b1;
    fetch(1'b1, 32'h0010_0093, 32'h100); settle();
    chk("t1_if_ready", {31'd0, if_ready_o}, 1);
    tick(); fetch(1'b0, '0, '0); dec(1, 1, 1, 0, 0, 0); settle();
    chk("t1_issue_valid", {31'd0, issue_valid_o}, 1);
    chk("t1_issue_pc", issue_pc_o, 32'h100);
    chk("t1_dec_instr", dec_instr_o, 32'h0010_0093);
    tick();

    // 2: add x2,x1,x1 stalls until one cycle after the x1 writeback
    fetch(1'b1, 32'h0010_8133, 32'h104); tick();
    fetch(1'b0, '0, '0); dec(1, 2, 1, 1, 1, 1); settle();
    chk("t2_stall0", {31'd0, issue_valid_o}, 0);
    tick(); settle();
    chk("t2_stall1", {31'd0, issue_valid_o}, 0);
    tick(); wb_valid_i = 1'b1; wb_rd_i = 5'd1; settle();
    chk("t2_stall_wb_cycle", {31'd0, issue_valid_o}, 0);
    tick(); wb_valid_i = 1'b0; settle();
    chk("t2_unblock", {31'd0, issue_valid_o}, 1);
    chk("t2_issue_pc", issue_pc_o, 32'h104);
    tick(); dec(0, 0, 0, 0, 0, 0);
    wb_valid_i = 1'b1; wb_rd_i = 5'd2; tick(); wb_valid_i = 1'b0;

    // 3: three pushes with execute stalled; queue fills at two, order preserved
    issue_ready_i = 1'b0;
    fetch(1'b1, 32'h0000_0013, 32'h300); settle();
    chk("t3_ready0", {31'd0, if_ready_o}, 1);
    tick(); fetch(1'b1, 32'h0000_0013, 32'h304); settle();
    chk("t3_ready1", {31'd0, if_ready_o}, 1);
    tick(); fetch(1'b1, 32'h0000_0013, 32'h308); settle();
    chk("t3_full_ready", {31'd0, if_ready_o}, 0);
    tick(); issue_ready_i = 1'b1; settle();
    chk("t3_head0_pc", dec_pc_o, 32'h300);
    chk("t3_head0_valid", {31'd0, issue_valid_o}, 1);
    tick(); settle();
    chk("t3_head1_pc", dec_pc_o, 32'h304);
    chk("t3_ready_after_pop", {31'd0, if_ready_o}, 1);
    tick(); fetch(1'b0, '0, '0); settle();
    chk("t3_head2_pc", dec_pc_o, 32'h308);
    tick(); settle();
    chk("t3_empty_instr", dec_instr_o, 32'h13);
    chk("t3_empty_valid", {31'd0, issue_valid_o}, 0);

    // 4: illegal instruction raises a held exception, then waits for flush
    fetch(1'b1, 32'h0000_0000, 32'h200); tick();
    fetch(1'b0, '0, '0); dec_illegal_i = 1'b1; settle();
    chk("t4_exc_valid", {31'd0, exc_valid_o}, 1);
    chk("t4_exc_pc", exc_pc_o, 32'h200);
    chk("t4_exc_tval", exc_tval_o, 32'h0);
    chk("t4_no_issue", {31'd0, issue_valid_o}, 0);
    tick(); settle();
    chk("t4_exc_held", {31'd0, exc_valid_o}, 1);
    chk("t4_exc_pc_held", exc_pc_o, 32'h200);
    exc_ready_i = 1'b1; tick(); exc_ready_i = 1'b0;
    fetch(1'b1, 32'h0000_0013, 32'h204); settle();
    chk("t4_trap_exc", {31'd0, exc_valid_o}, 0);
    chk("t4_trap_issue", {31'd0, issue_valid_o}, 0);
    chk("t4_trap_ready", {31'd0, if_ready_o}, 0);
    chk("t4_trap_head_kept", dec_pc_o, 32'h200);
    fetch(1'b0, '0, '0); flush_i = 1'b1; tick();
    flush_i = 1'b0; dec_illegal_i = 1'b0; settle();
    chk("t4_flush_empty", dec_instr_o, 32'h13);
    chk("t4_run_ready", {31'd0, if_ready_o}, 1);

    // 5: flush with a full queue drops everything but keeps busy[3]
    fetch(1'b1, 32'h0030_0193, 32'h400); tick();
    fetch(1'b0, '0, '0); dec(1, 3, 0, 0, 0, 0); settle();
    chk("t5_x3_issue", {31'd0, issue_valid_o}, 1);
    tick(); dec(0, 0, 0, 0, 0, 0); issue_ready_i = 1'b0;
    fetch(1'b1, 32'h0000_0013, 32'h404); tick();
    fetch(1'b1, 32'h0000_0013, 32'h408); tick();
    fetch(1'b1, 32'h0000_0013, 32'h40C); flush_i = 1'b1; settle();
    chk("t5_flush_ready", {31'd0, if_ready_o}, 0);
    chk("t5_flush_issue", {31'd0, issue_valid_o}, 0);
    tick(); flush_i = 1'b0; fetch(1'b0, '0, '0); settle();
    chk("t5_empty_instr", dec_instr_o, 32'h13);
    chk("t5_empty_pc", dec_pc_o, 32'h0);
    issue_ready_i = 1'b1;
    fetch(1'b1, 32'h0001_8213, 32'h410); tick();
    fetch(1'b0, '0, '0); dec(0, 0, 1, 3, 0, 0);
    wb_valid_i = 1'b1; wb_rd_i = 5'd3; settle();
    chk("t5_busy_kept", {31'd0, issue_valid_o}, 0);
    tick(); wb_valid_i = 1'b0; settle();
    chk("t5_unblock", {31'd0, issue_valid_o}, 1);
    tick(); dec(0, 0, 0, 0, 0, 0);

    // 6: x0 is never busy; set beats a same-cycle clear of x5
    fetch(1'b1, 32'h0000_0013, 32'h500); tick();
    fetch(1'b0, '0, '0); dec(1, 0, 1, 0, 0, 0); settle();
    chk("t6_x0_issue", {31'd0, issue_valid_o}, 1);
    tick(); fetch(1'b1, 32'h0000_0033, 32'h504); tick();
    fetch(1'b0, '0, '0); dec(1, 0, 1, 0, 1, 0); settle();
    chk("t6_x0_no_hazard", {31'd0, issue_valid_o}, 1);
    tick(); fetch(1'b1, 32'h0050_0293, 32'h508); tick();
    fetch(1'b0, '0, '0); dec(1, 5, 0, 0, 0, 0);
    wb_valid_i = 1'b1; wb_rd_i = 5'd5; settle();
    chk("t6_x5_issue", {31'd0, issue_valid_o}, 1);
    tick(); wb_valid_i = 1'b0; dec(0, 0, 0, 0, 0, 0);
    fetch(1'b1, 32'h0002_8313, 32'h50C); tick();
    fetch(1'b0, '0, '0); dec(0, 0, 1, 5, 0, 0);
    wb_valid_i = 1'b1; wb_rd_i = 5'd5; settle();
    chk("t6_x5_busy", {31'd0, issue_valid_o}, 0);
    tick(); wb_valid_i = 1'b0; settle();
    chk("t6_x5_unblock", {31'd0, issue_valid_o}, 1);
    tick(); dec(0, 0, 0, 0, 0, 0); settle();
    chk("t6_final_empty", {31'd0, issue_valid_o}, 0);

`ifdef DEC_PERF_CNT_EN
    chk("perf_issue", perf_issue_cnt_o, 32'd11);
    chk("perf_hazard", perf_hazard_cnt_o, 32'd5);
`endif

    // reset mid-operation discards a queued entry
    issue_ready_i = 1'b0;
    fetch(1'b1, 32'h0000_0013, 32'h600); tick();
    fetch(1'b0, '0, '0); reset_n = 1'b0; settle();
    chk("rst2_empty", dec_instr_o, 32'h13);
    chk("rst2_ready", {31'd0, if_ready_o}, 0);
    tick(); reset_n = 1'b1; settle();
    chk("rst2_ready_after", {31'd0, if_ready_o}, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
